// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// The state encoding is fixed so that it stays stable across the
// serial_adder top and anything else that observes its state.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half adders and an OR gate.
// This is the only arithmetic in the serial adder; it is evaluated once per
// clock on the LSBs of the operand shift registers.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  // First half adder combines the operand bits.
  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  // Second half adder folds in the incoming carry.
  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // Only one of the two half adders can generate a carry at a time.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder for two WIDTH-bit operands.
// Operands are accepted with a valid/ready handshake, one sum bit is produced
// per clock, and the registered result is offered with a second valid/ready
// handshake. Define SERIAL_ADDER_CIN_EN to add a carry_in port that seeds the
// carry flip-flop at the accept edge, allowing chained multi-word addition.

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             carry_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [CNT_W-1:0] count;

  logic             bit_s;
  logic             bit_c;
  logic             carry_init;
  logic             accept;
  logic             last_bit;

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_init = carry_in;
`else
  assign carry_init = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign last_bit = (count == LAST_CNT);

  // The single adder cell always looks at the current LSBs and the carry FF.
  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  // State register; reset drops any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded purely from the current state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand load, per-bit shifting, and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      count       <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      sum_sh  <= '0;
      carry_q <= carry_init;
      count   <= '0;
    end else if (state == ADD) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh  <= {bit_s, sum_sh[WIDTH-1:1]};
      carry_q <= bit_c;
      if (last_bit) begin
        sum_q       <= {bit_s, sum_sh[WIDTH-1:1]};
        carry_out_q <= bit_c;
        count       <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder for two WIDTH-bit operands. It sits downstream of the operand source and feeds the result consumer.
- Each bit is computed by a one-bit full-adder cell built from two half adders plus an OR gate. A carry flip-flop between cycles holds the carry.
- Trades area for latency: one sum bit per clock, result valid WIDTH cycles after operand acceptance.
- Uses a valid/ready handshake on both input and output.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b valid this cycle
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  sum/carry_out valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered sum
carry_out  output  1  registered final carry
busy  output  1  high while in ADD state

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, shift regs=0, carry FF=0, bit counter=0.
  - Output reset values: sum=0, carry_out=0, out_valid=0, busy=0, in_ready=1.
- States IDLE, ADD, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh<=a, b_sh<=b, carry FF<=0, count<=0, sum_sh<=0; go to ADD.
- ADD:
  - in_ready=0, busy=1.
  - Each cycle: s=a_sh[0]^b_sh[0]^c; c_next=majority(a_sh[0],b_sh[0],c).
  - sum_sh<={s,sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right with 0 fill; carry FF<=c_next; count<=count+1.
  - When count==WIDTH-1: perform the final bit, latch carry_out<=c_next, go to DONE.
- DONE:
  - out_valid=1; sum=sum_sh and carry_out held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle.
  - sum/carry_out keep their last value in IDLE.
- Latency: operands accepted at edge N; out_valid rises after edge N+WIDTH.
- Throughput: one addition per WIDTH+2 cycles minimum. No overlap: in_ready=0 in ADD and DONE.
- Counter width: $clog2(WIDTH). Terminal compare is exact; the counter never wraps in normal operation.
- Arithmetic: {carry_out,sum} == a+b (+carry_in when enabled), modulo 2^(WIDTH+1).
- Input changes while in ADD/DONE are ignored.
- Simultaneous events:
  - in_valid during DONE is not accepted.
  - out_ready in IDLE/ADD has no effect.
- Reset mid-operation (any state): immediate return to reset values. The partial result is discarded and not output.

Optional Feature:
- Macro: SERIAL_ADDER_CIN_EN.
- When defined:
  - Extra port carry_in (input, 1), sampled only at the IDLE accept edge.
  - carry_in initialises the carry FF, enabling chained multi-word addition.
- When undefined:
  - No carry_in port; carry FF initialises to 0.
  - All other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg:
  - state typedef (IDLE=2'd0, ADD=2'd1, DONE=2'd2).
  - Localparam CNT_W=$clog2(WIDTH) is computed inside the module, since it depends on WIDTH.
- One sub-module, full_adder_cell (a, b, cin -> s, cout):
  - Purely combinational, composed of two half-adder instances and an OR gate.
  - Instantiated once on the LSBs of the shift registers.
- All state, shift registers and handshake logic stay in serial_adder.

Test Plan:
- 1. Reset then a=8'h00, b=8'h00, in_valid pulse, out_ready=1 -> out_valid rises 8 cycles after accept; sum=8'h00, carry_out=0; busy high exactly 8 cycles.
- 2. a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1. Then a=8'hA5, b=8'h5A -> sum=8'hFF, carry_out=0.
- 3. Backpressure: a=8'h3C, b=8'h0F, out_ready=0 for 5 cycles after out_valid -> sum=8'h4B and out_valid held stable, in_ready=0 throughout. After out_ready=1: one handshake, then in_ready=1 next cycle.
- 4. Ignored input: new in_valid with a=8'h11 asserted during ADD -> result still reflects the first operands, and the second operand set is accepted only once back in IDLE.
- 5. Reset mid-operation: assert rst_n=0 asynchronously 3 cycles into ADD -> sum=0, carry_out=0, out_valid=0, busy=0, in_ready=1 immediately. After release, a=8'h80, b=8'h80 -> sum=8'h00, carry_out=1.
- 6. With SERIAL_ADDER_CIN_EN: a=8'hFF, b=8'h00, carry_in=1 -> sum=8'h00, carry_out=1. carry_in toggled during ADD has no effect.
